// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: op launch, MTHI/MTLO writes,
// and the busy/done/HI/LO results.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo, mt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo, mt_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on magnitudes, signs applied in a final cycle that writes HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op, sign_a, sign_b, div_by_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign signed_op   = ~bus.op[0];
  assign sign_a      = signed_op & bus.operand_a[WIDTH-1];
  assign sign_b      = signed_op & bus.operand_b[WIDTH-1];
  assign abs_a       = sign_a ? -bus.operand_a : bus.operand_a;
  assign abs_b       = sign_b ? -bus.operand_b : bus.operand_b;
  assign div_by_zero = bus.op[1] && (bus.operand_b == '0);

  // Multiply: {acc_hi, acc_lo} is the partial product with the multiplier shifting out of acc_lo.
  // Divide: acc_hi is the partial remainder, dividend bits shift out of acc_lo and quotient bits in.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_shift[WIDTH-1:0] - opnd_q;

  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod_raw = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod_raw : prod_raw;
  assign quot_fix = neg_lo_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_hi_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_CALC;
          count_d  = '0;
          is_div_d = bus.op[1];
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          acc_hi_d = '0;
          if (bus.op[1]) begin
            // A zero divisor on the raw dividend naturally yields all-ones quotient, remainder = dividend.
            if (div_by_zero) begin
              acc_lo_d = bus.operand_a;
              opnd_d   = '0;
              neg_lo_d = 1'b0;
              neg_hi_d = 1'b0;
            end else begin
              acc_lo_d = abs_a;
              opnd_d   = abs_b;
            end
          end else begin
            opnd_d   = abs_a;
            acc_lo_d = abs_b;
          end
        end else begin
          if (bus.mthi) hi_d = bus.mt_data;
          if (bus.mtlo) lo_d = bus.mt_data;
        end
      end

      ST_CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_rem : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) state_d = ST_FIN;
      end

      ST_FIN: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: ops push expected {hi,lo}, a monitor pops on each done pulse.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) m ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end else begin
      $display("ok   %s = %08h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (m.done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual hi=%08h lo=%08h expected no result", m.hi, m.lo);
        end else begin
          e = exp_q.pop_front();
          chk("result_hi", m.hi, e[63:32]);
          chk("result_lo", m.lo, e[31:0]);
        end
      end
    end
  end

  // mode 0: plain op; 1: mtlo in the start cycle; 2: start/mthi/mtlo pulsed mid-op
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int mode);
    logic [31:0] old_hi, old_lo;
    int cyc;
    int dc;
    @(negedge clk);
    old_hi = m.hi;
    old_lo = m.lo;
    dc = done_cnt;
    exp_q.push_back({eh, el});
    m.op = o;
    m.operand_a = a;
    m.operand_b = b;
    m.start = 1'b1;
    if (mode == 1) begin
      m.mtlo = 1'b1;
      m.mt_data = 32'h0000BEEF;
    end
    @(negedge clk);
    m.start = 1'b0;
    m.mtlo = 1'b0;
    if (mode == 1) chk("start_beats_mtlo", m.lo, old_lo);
    cyc = 0;
    while (m.busy === 1'b1 && cyc < 100) begin
      if (mode == 2 && cyc == 5) begin
        m.start = 1'b1;
        m.op = 2'b00;
        m.operand_a = 32'd9;
        m.operand_b = 32'd9;
        m.mthi = 1'b1;
        m.mtlo = 1'b1;
        m.mt_data = 32'h0000DEAD;
      end
      if (mode == 2 && cyc == 6) begin
        m.start = 1'b0;
        m.mthi = 1'b0;
        m.mtlo = 1'b0;
      end
      if (mode == 2 && cyc == 8) begin
        chk("hi_held_while_busy", m.hi, old_hi);
        chk("lo_held_while_busy", m.lo, old_lo);
      end
      cyc++;
      @(negedge clk);
    end
    chk("busy_cycles", cyc, 33);
    chk("done_pulse", {31'd0, m.done}, 32'd1);
    @(negedge clk);
    chk("done_clear", {31'd0, m.done}, 32'd0);
    if (mode == 2) begin
      repeat (40) @(negedge clk);
      chk("single_done", done_cnt - dc, 32'd1);
    end
  endtask

  initial begin
    int dc;
    m.start = 1'b0;
    m.op = 2'b00;
    m.operand_a = '0;
    m.operand_b = '0;
    m.mthi = 1'b0;
    m.mtlo = 1'b0;
    m.mt_data = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, m.busy}, 32'd0);
    chk("reset_done", {31'd0, m.done}, 32'd0);
    chk("reset_hi", m.hi, 32'd0);
    chk("reset_lo", m.lo, 32'd0);
    rst_n = 1'b1;

    run_op(2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

    @(negedge clk);
    m.mthi = 1'b1;
    m.mt_data = 32'h00001234;
    @(negedge clk);
    m.mthi = 1'b0;
    chk("mthi_hi", m.hi, 32'h00001234);
    chk("mthi_lo_kept", m.lo, 32'h80000000);
    m.mthi = 1'b1;
    m.mtlo = 1'b1;
    m.mt_data = 32'h00005678;
    @(negedge clk);
    m.mthi = 1'b0;
    m.mtlo = 1'b0;
    chk("mtboth_hi", m.hi, 32'h00005678);
    chk("mtboth_lo", m.lo, 32'h00005678);
    m.mtlo = 1'b1;
    m.mt_data = 32'h00009ABC;
    @(negedge clk);
    m.mtlo = 1'b0;
    chk("mtlo_lo", m.lo, 32'h00009ABC);
    chk("mtlo_hi_kept", m.hi, 32'h00005678);

    run_op(2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 1);
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 2);
    run_op(2'b10, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 0);

    @(negedge clk);
    m.op = 2'b01;
    m.operand_a = 32'd7;
    m.operand_b = 32'd6;
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    repeat (9) @(negedge clk);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, m.busy}, 32'd0);
    chk("abort_hi", m.hi, 32'd0);
    chk("abort_lo", m.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 32'd0);
    chk("abort_lo_stays", m.lo, 32'd0);

    run_op(2'b01, 32'd7, 32'd6, 32'd0, 32'd42, 0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
